alu_rr_arbiter: RTL

- Shares one ALU instance between N requesters using round-robin arbitration. The ALU registers its operands on CLOCK and presents Z/FLAGS ALU_LAT cycles later.
- The block issues at most one operation per cycle into the ALU. It tracks in-flight operations in a tag pipeline and returns each result to the requester that issued it.
- It sits between the ALU and the per-unit operand sources (register read ports, address generation, and so on).

---
 rtl/alu_rr_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one pipelined ALU among N requesters; grant is combinational,
// result returns ALU_LAT+1 cycles after the grant, and a requester simply holds REQ until granted.
module alu_rr_arbiter #(
   parameter int N       = 4,
   parameter int ALU_LAT = 1,
   parameter int IDW     = 3
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [N-1:0]      REQ,
   input  logic [32*N-1:0]   REQ_A,
   input  logic [32*N-1:0]   REQ_B,
   input  logic [4*N-1:0]    REQ_INST,
   output logic [N-1:0]      GNT,
   output logic [31:0]       ALU_A,
   output logic [31:0]       ALU_B,
   output logic [3:0]        ALU_INST,
   input  logic [31:0]       ALU_Z,
   input  logic [3:0]        ALU_FLAGS,
   output logic [N-1:0]      RSP_VALID,
   output logic [31:0]       RSP_Z,
   output logic [3:0]        RSP_FLAGS,
   output logic              RSP_ERR,
   output logic              BUSY
);

   localparam logic [3:0] OP_ZERO  = 4'hE;
   localparam logic [3:0] OP_UNSUP = 4'h6;

   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [N-1:0]       hi_mask, pick;
   logic               gnt_vld;
   logic [IDW-1:0]     gnt_id;

   logic [ALU_LAT-1:0] tag_vld_q;
   logic [ALU_LAT-1:0] tag_err_q;
   logic [IDW-1:0]     tag_id_q [ALU_LAT];

   logic [N-1:0]       rsp_vld_q;
   logic [31:0]        rsp_z_q;
   logic [3:0]         rsp_flags_q;
   logic               rsp_err_q;
   logic               busy_q;
   logic               busy_d;

   // Requests at or above the pointer take precedence; otherwise wrap to the lowest index.
   always_comb begin
      hi_mask = REQ & ~((N'(1) << ptr_q) - N'(1));
      pick    = (|hi_mask) ? hi_mask : REQ;
      gnt_vld = (|REQ) & ~RESET;
      gnt_id  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pick[i]) gnt_id = IDW'(i);
      end
      ptr_d = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
      GNT   = gnt_vld ? (N'(1) << gnt_id) : '0;
   end

   always_comb begin
      ALU_A    = '0;
      ALU_B    = '0;
      ALU_INST = OP_ZERO;
      for (int i = 0; i < N; i++) begin
         if (GNT[i]) begin
            ALU_A    = REQ_A[32*i +: 32];
            ALU_B    = REQ_B[32*i +: 32];
            ALU_INST = REQ_INST[4*i +: 4];
         end
      end
   end

   // BUSY covers the tag stages only; the response register acts as the last stage.
   assign busy_d = gnt_vld | (|(tag_vld_q << 1));

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         ptr_q       <= '0;
         tag_vld_q   <= '0;
         tag_err_q   <= '0;
         for (int i = 0; i < ALU_LAT; i++) tag_id_q[i] <= '0;
         rsp_vld_q   <= '0;
         rsp_z_q     <= '0;
         rsp_flags_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (gnt_vld) ptr_q <= ptr_d;
         tag_vld_q   <= (tag_vld_q << 1) | ALU_LAT'(gnt_vld);
         tag_err_q   <= (tag_err_q << 1) | ALU_LAT'(ALU_INST == OP_UNSUP);
         tag_id_q[0] <= gnt_id;
         for (int i = 1; i < ALU_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
         busy_q      <= busy_d;
         if (tag_vld_q[ALU_LAT-1]) begin
            rsp_vld_q   <= N'(1) << tag_id_q[ALU_LAT-1];
            rsp_z_q     <= ALU_Z;
            rsp_flags_q <= ALU_FLAGS;
            rsp_err_q   <= tag_err_q[ALU_LAT-1];
         end else begin
            rsp_vld_q   <= '0;
         end
      end
   end

   assign RSP_VALID = rsp_vld_q;
   assign RSP_Z     = rsp_z_q;
   assign RSP_FLAGS = rsp_flags_q;
   assign RSP_ERR   = rsp_err_q;
   assign BUSY      = busy_q;

endmodule
